// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the memory-port arbiter, its two requesters
// (A = instruction fetch, B = data load/store) and the shared memory port.
// The arbiter connects through the master view; the environment uses slave.
interface mem_port_arbiter_if #(
   parameter int WORDSIZE = 64,
   parameter int ADDRSIZE = 64
);

   // Requester A
   logic                a_req;
   logic [ADDRSIZE-1:0] a_addr;
   logic [WORDSIZE-1:0] a_wdata;
   logic                a_we;
   logic                a_ack;
   logic [WORDSIZE-1:0] a_rdata;

   // Requester B
   logic                b_req;
   logic [ADDRSIZE-1:0] b_addr;
   logic [WORDSIZE-1:0] b_wdata;
   logic                b_we;
   logic                b_ack;
   logic [WORDSIZE-1:0] b_rdata;

   // Shared memory port and bus-steering select (0 = A, 1 = B)
   logic                mem_req;
   logic [ADDRSIZE-1:0] mem_addr;
   logic [WORDSIZE-1:0] mem_wdata;
   logic                mem_we;
   logic                mem_ready;
   logic [WORDSIZE-1:0] mem_rdata;
   logic                sel;

   modport master (
      input  a_req, a_addr, a_wdata, a_we,
      output a_ack, a_rdata,
      input  b_req, b_addr, b_wdata, b_we,
      output b_ack, b_rdata,
      output mem_req, mem_addr, mem_wdata, mem_we, sel,
      input  mem_ready, mem_rdata
   );

   modport slave (
      output a_req, a_addr, a_wdata, a_we,
      input  a_ack, a_rdata,
      output b_req, b_addr, b_wdata, b_we,
      input  b_ack, b_rdata,
      input  mem_req, mem_addr, mem_wdata, mem_we, sel,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch
// requester (A) and a data requester (B). One transaction at a time; every
// output is a register. A transaction walks IDLE -> BUSY_x -> ACK -> IDLE,
// so back-to-back requests from both ports alternate A, B, A, B.
module mem_port_arbiter #(
   parameter int WORDSIZE = 64,
   parameter int ADDRSIZE = 64
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_A,
      BUSY_B,
      ACK
   } state_t;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   // Control state
   state_t              r_state;
   state_t              w_state_nxt;
   port_t               r_last_grant;
   port_t               w_last_grant_nxt;

   // Registered outputs and their next values
   logic                r_mem_req,   w_mem_req_nxt;
   logic [ADDRSIZE-1:0] r_mem_addr,  w_mem_addr_nxt;
   logic [WORDSIZE-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic                r_mem_we,    w_mem_we_nxt;
   logic                r_sel,       w_sel_nxt;
   logic                r_a_ack,     w_a_ack_nxt;
   logic                r_b_ack,     w_b_ack_nxt;
   logic [WORDSIZE-1:0] r_a_rdata,   w_a_rdata_nxt;
   logic [WORDSIZE-1:0] r_b_rdata,   w_b_rdata_nxt;

   // Arbitration decision and the selected requester's transaction fields
   logic                w_any_req;
   logic                w_grant_b;
   logic [ADDRSIZE-1:0] w_req_addr;
   logic [WORDSIZE-1:0] w_req_wdata;
   logic                w_req_we;

   // Pick the winner: a lone requester wins; on a tie the port that was
   // not served last wins, which gives strict alternation under load.
   always_comb begin
      w_any_req   = bus.a_req | bus.b_req;
      w_grant_b   = bus.b_req & (~bus.a_req | (r_last_grant == PORT_A));
      w_req_addr  = w_grant_b ? bus.b_addr  : bus.a_addr;
      w_req_wdata = w_grant_b ? bus.b_wdata : bus.a_wdata;
      w_req_we    = w_grant_b ? bus.b_we    : bus.a_we;
   end

   // Next-state and next-output logic of the transaction FSM.
   always_comb begin
      // NOTE: every signal gets a hold-value default before the case so
      // that no path leaves a signal unassigned and no latch is inferred.
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      w_mem_req_nxt    = r_mem_req;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = r_mem_wdata;
      w_mem_we_nxt     = r_mem_we;
      w_sel_nxt        = r_sel;
      w_a_ack_nxt      = r_a_ack;
      w_b_ack_nxt      = r_b_ack;
      w_a_rdata_nxt    = r_a_rdata;
      w_b_rdata_nxt    = r_b_rdata;

      case (r_state)
         IDLE: begin
            // mem_ready is meaningless here: nothing is outstanding.
            if (w_any_req) begin
               w_mem_req_nxt   = 1'b1;
               w_mem_addr_nxt  = w_req_addr;
               w_mem_wdata_nxt = w_req_wdata;
               w_mem_we_nxt    = w_req_we;
               w_sel_nxt       = w_grant_b;
               w_state_nxt     = w_grant_b ? BUSY_B : BUSY_A;
            end
         end

         BUSY_A, BUSY_B: begin
            // Address/data/select stay frozen from the grant; requester
            // inputs (including a dropped req) are not looked at again.
            if (bus.mem_ready) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = ACK;
               if (r_state == BUSY_B) begin
                  w_b_ack_nxt      = 1'b1;
                  w_last_grant_nxt = PORT_B;
                  if (!r_mem_we) begin
                     w_b_rdata_nxt = bus.mem_rdata;
                  end
               end else begin
                  w_a_ack_nxt      = 1'b1;
                  w_last_grant_nxt = PORT_A;
                  if (!r_mem_we) begin
                     w_a_rdata_nxt = bus.mem_rdata;
                  end
               end
            end
         end

         ACK: begin
            // Single cycle in which the ack is visible; requests wait.
            w_a_ack_nxt = 1'b0;
            w_b_ack_nxt = 1'b0;
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and round-robin pointer; after reset B counts as last served so
   // A wins the first tie.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= PORT_B;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   // Output registers; reset clears everything, including read data, and
   // abandons any transaction in flight without an ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_sel       <= 1'b0;
         r_a_ack     <= 1'b0;
         r_b_ack     <= 1'b0;
         r_a_rdata   <= '0;
         r_b_rdata   <= '0;
      end else begin
         r_mem_req   <= w_mem_req_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_sel       <= w_sel_nxt;
         r_a_ack     <= w_a_ack_nxt;
         r_b_ack     <= w_b_ack_nxt;
         r_a_rdata   <= w_a_rdata_nxt;
         r_b_rdata   <= w_b_rdata_nxt;
      end
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_we    = r_mem_we;
   assign bus.sel       = r_sel;
   assign bus.a_ack     = r_a_ack;
   assign bus.b_ack     = r_b_ack;
   assign bus.a_rdata   = r_a_rdata;
   assign bus.b_rdata   = r_b_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters, memory and resets, all checked every cycle
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

   localparam int W = 64;
   localparam int A = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.WORDSIZE(W), .ADDRSIZE(A)) bus ();

   mem_port_arbiter #(.WORDSIZE(W), .ADDRSIZE(A)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Stimulus, indexed by port (0 = A, 1 = B)
   logic         t_req   [2];
   logic [A-1:0] t_addr  [2];
   logic [W-1:0] t_wdata [2];
   logic         t_we    [2];
   logic         mem_ready;
   logic [W-1:0] mem_rdata;

   assign bus.a_req     = t_req[0];
   assign bus.a_addr    = t_addr[0];
   assign bus.a_wdata   = t_wdata[0];
   assign bus.a_we      = t_we[0];
   assign bus.b_req     = t_req[1];
   assign bus.b_addr    = t_addr[1];
   assign bus.b_wdata   = t_wdata[1];
   assign bus.b_we      = t_we[1];
   assign bus.mem_ready = mem_ready;
   assign bus.mem_rdata = mem_rdata;

   wire [1:0] ack = {bus.b_ack, bus.a_ack};

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;
   bit auto_mem = 1'b0;
   bit auto_rst = 1'b0;
   bit auto_req [2] = '{1'b0, 1'b0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Whole-transaction view: who owns the port (-1 = nobody), whether the
   // one-cycle completion window is open, and whose turn it is on a tie.
   int           m_owner  = -1;
   bit           m_done   = 1'b0;
   int           m_prefer = 0;
   int           m_pick;
   logic         m_mem_req;
   logic [A-1:0] m_addr;
   logic [W-1:0] m_wdata;
   logic         m_we;
   logic         m_sel;
   logic         m_ack   [2];
   logic [W-1:0] m_rdata [2];
   int           m_grants [$];

   always @(posedge clk) begin
      if (reset) begin
         m_owner = -1; m_done = 1'b0; m_prefer = 0;
         m_mem_req = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_sel = 1'b0;
         m_ack[0] = 1'b0; m_ack[1] = 1'b0; m_rdata[0] = '0; m_rdata[1] = '0;
      end else if (m_done) begin
         m_done = 1'b0;
         m_ack[0] = 1'b0;
         m_ack[1] = 1'b0;
      end else if (m_owner < 0) begin
         m_pick = -1;
         if (t_req[0] && t_req[1]) m_pick = m_prefer;
         else if (t_req[0])        m_pick = 0;
         else if (t_req[1])        m_pick = 1;
         if (m_pick >= 0) begin
            m_owner   = m_pick;
            m_mem_req = 1'b1;
            m_addr    = t_addr[m_pick];
            m_wdata   = t_wdata[m_pick];
            m_we      = t_we[m_pick];
            m_sel     = (m_pick == 1);
            m_grants.push_back(m_pick);
         end
      end else if (mem_ready) begin
         m_mem_req      = 1'b0;
         m_ack[m_owner] = 1'b1;
         if (!m_we) m_rdata[m_owner] = mem_rdata;
         m_prefer = 1 - m_owner;
         m_owner  = -1;
         m_done   = 1'b1;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_req",   bus.mem_req,   m_mem_req);
         check("mem_addr",  bus.mem_addr,  m_addr);
         check("mem_wdata", bus.mem_wdata, m_wdata);
         check("mem_we",    bus.mem_we,    m_we);
         check("sel",       bus.sel,       m_sel);
         check("a_ack",     bus.a_ack,     m_ack[0]);
         check("b_ack",     bus.b_ack,     m_ack[1]);
         check("a_rdata",   bus.a_rdata,   m_rdata[0]);
         check("b_rdata",   bus.b_rdata,   m_rdata[1]);
      end
   end

   // Grant order as seen on the DUT: sel at each rising edge of mem_req
   int   dut_grants [$];
   logic prev_mem_req = 1'b0;
   always @(negedge clk) begin
      if (bus.mem_req === 1'b1 && prev_mem_req !== 1'b1) dut_grants.push_back(int'(bus.sel));
      prev_mem_req = bus.mem_req;
   end

   // One clock step; inputs change just after the falling edge.
   task automatic tick();
      @(negedge clk);
      if (auto_rst) reset = ($urandom_range(0, 199) == 0);
      if (auto_mem) begin
         mem_ready = !mem_ready && ($urandom_range(0, 2) == 0);
         mem_rdata = {$urandom, $urandom};
      end
      for (int p = 0; p < 2; p++) begin
         if (auto_req[p]) begin
            if (t_req[p]) begin
               if (ack[p]) t_req[p] = 1'b0;
               else if ($urandom_range(0, 7) == 0) t_addr[p] = {$urandom, $urandom};
            end else if ($urandom_range(0, 3) == 0) begin
               t_req[p]   = 1'b1;
               t_addr[p]  = {$urandom, $urandom};
               t_wdata[p] = {$urandom, $urandom};
               t_we[p]    = 1'($urandom_range(0, 1));
            end
         end
      end
   endtask

   initial begin
      int cyc;
      reset = 1'b1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      for (int p = 0; p < 2; p++) begin
         t_req[p] = 1'b0; t_addr[p] = '0; t_wdata[p] = '0; t_we[p] = 1'b0;
      end
      tick();
      tick();
      chk_en = 1'b1;

      // Reset state
      check("rst_mem_req", bus.mem_req, 64'd0);
      check("rst_sel",     bus.sel,     64'd0);
      check("rst_a_rdata", bus.a_rdata, 64'd0);
      check("rst_b_rdata", bus.b_rdata, 64'd0);

      // A read, memory answers in the third BUSY cycle
      reset = 1'b0;
      t_req[0] = 1'b1; t_addr[0] = 64'h1000; t_wdata[0] = '0; t_we[0] = 1'b0;
      tick();
      check("a_rd_mem_req",  bus.mem_req,  64'd1);
      check("a_rd_mem_addr", bus.mem_addr, 64'h1000);
      check("a_rd_sel",      bus.sel,      64'd0);
      tick();
      tick();
      mem_ready = 1'b1; mem_rdata = 64'h0000_0000_0000_aaaa;
      tick();
      mem_ready = 1'b0; mem_rdata = '0;
      check("a_rd_ack",      bus.a_ack,   64'd1);
      check("a_rd_rdata",    bus.a_rdata, 64'haaaa);
      check("a_rd_b_ack",    bus.b_ack,   64'd0);
      check("model_a_rdata", m_rdata[0],  64'haaaa);
      t_req[0] = 1'b0;
      tick();
      check("a_rd_ack_clr", bus.a_ack, 64'd0);

      // B write; mem_ready also held into the ACK cycle (must be ignored)
      t_req[1] = 1'b1; t_addr[1] = 64'h2000; t_wdata[1] = 64'h0000_0000_0000_bbbb; t_we[1] = 1'b1;
      tick();
      check("b_wr_mem_we",    bus.mem_we,    64'd1);
      check("b_wr_mem_wdata", bus.mem_wdata, 64'hbbbb);
      check("b_wr_mem_addr",  bus.mem_addr,  64'h2000);
      check("b_wr_sel",       bus.sel,       64'd1);
      mem_ready = 1'b1; mem_rdata = 64'h0000_0000_dead_beef;
      tick();
      check("b_wr_ack",   bus.b_ack,   64'd1);
      check("b_wr_rdata", bus.b_rdata, 64'd0);
      t_req[1] = 1'b0;
      tick();
      mem_ready = 1'b0;
      check("ack_spur_b_ack",   bus.b_ack,   64'd0);
      check("ack_spur_mem_req", bus.mem_req, 64'd0);
      check("ack_spur_sel",     bus.sel,     64'd1);

      // Spurious mem_ready in IDLE
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("idle_spur_mem_req", bus.mem_req, 64'd0);
      check("idle_spur_a_ack",   bus.a_ack,   64'd0);
      check("idle_spur_b_ack",   bus.b_ack,   64'd0);

      // Tie after reset: both held, expect grants A,B,A,B
      reset = 1'b1;
      tick();
      reset = 1'b0;
      dut_grants.delete();
      m_grants.delete();
      t_req[0] = 1'b1; t_addr[0] = 64'h3000; t_we[0] = 1'b0;
      t_req[1] = 1'b1; t_addr[1] = 64'h4000; t_we[1] = 1'b0;
      auto_mem = 1'b1;
      cyc = 0;
      while (dut_grants.size() < 4 && cyc < 200) begin
         tick();
         cyc++;
      end
      if (dut_grants.size() < 4) check("tie_timeout", 64'(dut_grants.size()), 64'd4);
      for (int i = 0; i < 4 && i < dut_grants.size(); i++) begin
         check("tie_grant_dut", 64'(dut_grants[i]), 64'(i % 2));
      end
      for (int i = 0; i < 4 && i < m_grants.size(); i++) begin
         check("tie_grant_model", 64'(m_grants[i]), 64'(i % 2));
      end
      t_req[0] = 1'b0;
      t_req[1] = 1'b0;
      cyc = 0;
      while ((bus.mem_req !== 1'b0 || ack !== 2'b00) && cyc < 100) begin
         tick();
         cyc++;
      end
      if (cyc >= 100) check("tie_drain_timeout", 64'(bus.mem_req), 64'd0);
      auto_mem = 1'b0;
      mem_ready = 1'b0;
      tick();

      // B drops req mid-transaction; completion and ack still happen
      t_req[1] = 1'b1; t_addr[1] = 64'h5000; t_we[1] = 1'b0;
      tick();
      check("b_drop_mem_req", bus.mem_req, 64'd1);
      check("b_drop_sel",     bus.sel,     64'd1);
      t_req[1] = 1'b0;
      tick();
      tick();
      mem_ready = 1'b1; mem_rdata = 64'h5555;
      tick();
      mem_ready = 1'b0;
      check("b_drop_ack",   bus.b_ack,   64'd1);
      check("b_drop_rdata", bus.b_rdata, 64'h5555);
      tick();
      check("b_drop_ack_clr", bus.b_ack, 64'd0);

      // Reset in the middle of BUSY_A
      t_req[0] = 1'b1; t_addr[0] = 64'h6000; t_we[0] = 1'b0;
      tick();
      check("rst_busy_mem_req", bus.mem_req, 64'd1);
      tick();
      reset = 1'b1;
      t_req[0] = 1'b0;
      tick();
      reset = 1'b0;
      check("rst_busy_mem_req0", bus.mem_req,  64'd0);
      check("rst_busy_addr",     bus.mem_addr, 64'd0);
      check("rst_busy_a_rdata",  bus.a_rdata,  64'd0);
      check("rst_busy_b_rdata",  bus.b_rdata,  64'd0);
      check("rst_busy_a_ack",    bus.a_ack,    64'd0);
      mem_ready = 1'b1; mem_rdata = 64'h7777;
      tick();
      mem_ready = 1'b0;
      check("rst_late_ready_ack", bus.a_ack,   64'd0);
      check("rst_late_ready_req", bus.mem_req, 64'd0);

      // Randomized traffic with occasional resets
      auto_mem = 1'b1;
      auto_rst = 1'b1;
      auto_req[0] = 1'b1;
      auto_req[1] = 1'b1;
      repeat (3000) tick();
      auto_rst = 1'b0;
      auto_mem = 1'b0;
      auto_req[0] = 1'b0;
      auto_req[1] = 1'b0;
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
